// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register at the fetch end of the PC datapath.
// Selects the next PC from the sequential value (PCAddResult) or a redirect
// (jr/jalr, taken branch, j/jal). It holds the PC during stalls and parks any
// redirect that arrives mid-stall until the stall releases.
// Optional feature macro: PC_EXC_VECTOR_EN adds an Exception input that forces
// the PC to EXC_VECTOR, overriding stalls and any parked redirect.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
`ifdef PC_EXC_VECTOR_EN
    input  logic        Exception,
`endif
    output logic [31:0] PCResult,
    output logic        PCValid,
    output logic        RedirectPending,
    output logic        Misaligned
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pending;

    logic        redir;
    logic [31:0] jump_tgt;
    logic [31:0] raw_tgt;
    logic [31:0] redir_tgt;
    logic        redir_mis;
    logic        take_exc;

`ifdef PC_EXC_VECTOR_EN
    assign take_exc = Exception && (state != BOOT);
`else
    // No exception path in this build; the vector parameter is kept only so
    // both builds share one parameter list.
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
    assign take_exc          = 1'b0;
`endif

    // Redirect target selection: JumpReg > BranchTaken > Jump, low bits forced to 0.
    always_comb begin
        redir    = JumpReg | BranchTaken | Jump;
        jump_tgt = {PCAddResult[31:28], JumpIndex, 2'b00};
        if (JumpReg)
            raw_tgt = JumpRegTarget;
        else if (BranchTaken)
            raw_tgt = BranchTarget;
        else
            raw_tgt = jump_tgt;
        redir_tgt = {raw_tgt[31:2], 2'b00};
        // Jump targets are aligned by construction, so only jr/branch can trip this.
        redir_mis = redir && (raw_tgt[1:0] != 2'b00);
    end

    // PC state machine with registered outputs and the sticky misalignment flag.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state           <= BOOT;
            PCResult        <= RESET_PC;
            PCValid         <= 1'b0;
            RedirectPending <= 1'b0;
            Misaligned      <= 1'b0;
            pending         <= 32'h0;
        end else if (take_exc) begin
`ifdef PC_EXC_VECTOR_EN
            PCResult        <= EXC_VECTOR;
`endif
            pending         <= 32'h0;
            RedirectPending <= 1'b0;
            state           <= RUN;
        end else begin
            // Any redirect acted on (loaded or parked) with bad low bits is flagged.
            if (state != BOOT && redir_mis)
                Misaligned <= 1'b1;

            case (state)
                BOOT: begin
                    // One settling cycle: PC stays at RESET_PC, inputs ignored.
                    state   <= RUN;
                    PCValid <= 1'b1;
                end
                RUN: begin
                    if (Stall) begin
                        if (redir) begin
                            pending         <= redir_tgt;
                            RedirectPending <= 1'b1;
                            state           <= HOLD;
                        end
                    end else begin
                        PCResult <= redir ? redir_tgt : PCAddResult;
                    end
                end
                HOLD: begin
                    if (Stall) begin
                        // Newest redirect replaces the parked one.
                        if (redir)
                            pending <= redir_tgt;
                    end else begin
                        // A redirect arriving on the release cycle beats the parked one.
                        PCResult        <= redir ? redir_tgt : pending;
                        RedirectPending <= 1'b0;
                        state           <= RUN;
                    end
                end
                default: begin
                    state           <= BOOT;
                    PCValid         <= 1'b0;
                    RedirectPending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model that
// tracks only the PC, a "booting" flag and an optional parked redirect.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] PCAddResult;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
    logic        Exception;
    logic [31:0] PCResult;
    logic        PCValid;
    logic        RedirectPending;
    logic        Misaligned;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_boot;
    logic        m_pend;
    logic [31:0] m_pend_tgt;
    logic        m_mis;

    always #5 Clk = ~Clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .PCAddResult(PCAddResult),
        .Stall(Stall),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpIndex(JumpIndex),
        .JumpReg(JumpReg),
        .JumpRegTarget(JumpRegTarget),
`ifdef PC_EXC_VECTOR_EN
        .Exception(Exception),
`endif
        .PCResult(PCResult),
        .PCValid(PCValid),
        .RedirectPending(RedirectPending),
        .Misaligned(Misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_valid = 1'b0; m_boot = 1'b1;
        m_pend = 1'b0; m_pend_tgt = 32'h0; m_mis = 1'b0;
    endtask

    // One clock edge of the architectural behaviour.
    task automatic model_edge();
        logic        any;
        logic [31:0] t;
        any = JumpReg || BranchTaken || Jump;
        if (JumpReg)          t = JumpRegTarget;
        else if (BranchTaken) t = BranchTarget;
        else                  t = {PCAddResult[31:28], JumpIndex, 2'b00};
        if (m_boot) begin
            m_boot = 1'b0; m_valid = 1'b1;
        end else if (Exception) begin
            m_pc = EXC_VECTOR; m_pend = 1'b0;
        end else begin
            if (any && t[1:0] != 2'b00) m_mis = 1'b1;
            t = t & 32'hFFFF_FFFC;
            if (Stall) begin
                if (any) begin m_pend = 1'b1; m_pend_tgt = t; end
            end else begin
                if (any)         m_pc = t;
                else if (m_pend) m_pc = m_pend_tgt;
                else             m_pc = PCAddResult;
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pc"},    PCResult, m_pc);
        chk({tag, ".valid"}, 32'(PCValid), 32'(m_valid));
        chk({tag, ".rp"},    32'(RedirectPending), 32'(m_pend));
        chk({tag, ".mis"},   32'(Misaligned), 32'(m_mis));
    endtask

    task automatic clear_in();
        Stall = 0; BranchTaken = 0; BranchTarget = 0; Jump = 0; JumpIndex = 0;
        JumpReg = 0; JumpRegTarget = 0; Exception = 0;
    endtask

    // Advance one clock: model sees the inputs at the edge, outputs checked 1 unit later.
    task automatic tick(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_outputs(tag);
        PCAddResult = m_pc + 32'd4;
    endtask

    // Asynchronous reset pulse placed away from clock edges.
    task automatic do_reset(input string tag);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        chk({tag, ".rst_pc"},  PCResult, RESET_PC);
        chk({tag, ".rst_mis"}, 32'(Misaligned), 32'd0);
        check_outputs(tag);
        PCAddResult = m_pc + 32'd4;
        #1 Reset = 1'b1;
    endtask

    task automatic jr_to(input logic [31:0] a);
        clear_in(); JumpReg = 1; JumpRegTarget = a;
        tick("jr_to");
        clear_in();
    endtask

    initial begin
        clear_in();
        Reset = 1'b0;
        PCAddResult = 32'd4;
        model_reset();
        #12;
        check_outputs("reset");
        Reset = 1'b1;

        // Sequential fetch from reset: boot edge keeps PC, then +4 per edge.
        for (int i = 0; i < 4; i++) begin
            tick("seq");
            chk("seq_const", PCResult, 32'(i * 4));
        end

        // Priority: Branch beats Jump, JumpReg beats Branch.
        jr_to(32'h100);
        BranchTaken = 1; BranchTarget = 32'h200; Jump = 1; JumpIndex = 26'h40;
        tick("br_vs_j");
        chk("br_vs_j_const", PCResult, 32'h200);
        clear_in(); JumpReg = 1; JumpRegTarget = 32'h300; BranchTaken = 1; BranchTarget = 32'h500;
        tick("jr_vs_br");
        chk("jr_vs_br_const", PCResult, 32'h300);

        // Wrap-around of the sequential PC.
        jr_to(32'hFFFF_FFFC);
        tick("wrap");
        chk("wrap_const", PCResult, 32'h0);

        // Redirect during stall is parked and applied on release.
        jr_to(32'h100);
        Stall = 1; BranchTaken = 1; BranchTarget = 32'h400;
        tick("stall1");
        BranchTaken = 0;
        tick("stall2");
        tick("stall3");
        chk("stall_pc", PCResult, 32'h100);
        chk("stall_rp", 32'(RedirectPending), 32'd1);
        Stall = 0;
        tick("release");
        chk("release_pc", PCResult, 32'h400);
        chk("release_rp", 32'(RedirectPending), 32'd0);

        // New jump on the release cycle beats the parked target.
        jr_to(32'h100);
        Stall = 1; BranchTaken = 1; BranchTarget = 32'h400;
        tick("hold1");
        BranchTaken = 0;
        tick("hold2");
        Stall = 0; Jump = 1; JumpIndex = 26'h10; PCAddResult = 32'h104;
        tick("rel_jump");
        chk("rel_jump_pc", PCResult, 32'h40);

        // Misaligned target is truncated, flag is sticky until reset.
        jr_to(32'h1003);
        chk("mis_pc", PCResult, 32'h1000);
        chk("mis_flag", 32'(Misaligned), 32'd1);
        for (int i = 0; i < 10; i++) tick("mis_hold");
        chk("mis_sticky", 32'(Misaligned), 32'd1);
        do_reset("midrst");
        tick("boot2");

`ifdef PC_EXC_VECTOR_EN
        jr_to(32'h100);
        Stall = 1; BranchTaken = 1; BranchTarget = 32'h400;
        tick("exc_park");
        BranchTaken = 0; Exception = 1;
        tick("exc");
        chk("exc_pc", PCResult, EXC_VECTOR);
        chk("exc_rp", 32'(RedirectPending), 32'd0);
        Exception = 0; Stall = 0;
        tick("exc_next");
        chk("exc_next_pc", PCResult, EXC_VECTOR + 32'd4);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            clear_in();
            Stall        = ($urandom_range(0, 3) == 0);
            BranchTaken  = ($urandom_range(0, 5) == 0);
            Jump         = ($urandom_range(0, 5) == 0);
            JumpReg      = ($urandom_range(0, 7) == 0);
            BranchTarget = $urandom;
            JumpRegTarget= $urandom;
            if ($urandom_range(0, 3) != 0) begin
                BranchTarget  = BranchTarget & 32'hFFFF_FFFC;
                JumpRegTarget = JumpRegTarget & 32'hFFFF_FFFC;
            end
            JumpIndex = 26'($urandom);
`ifdef PC_EXC_VECTOR_EN
            Exception = ($urandom_range(0, 30) == 0);
`endif
            if ($urandom_range(0, 9) == 0) PCAddResult = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rnd_rst");
            end else begin
                tick("rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter state holder at the fetch end of the PC datapath.
- Drives PCResult into the PC+4 adder and instruction memory.
- Each cycle it selects the next PC from the incremented value (PCAddResult) or a redirect target.
- Handles pipeline stalls, and holds any redirect that arrives during a stall until the stall releases.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- EXC_VECTOR, 32'h80000180, exception entry address. Used only with PC_EXC_VECTOR_EN.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- PCAddResult  input  32  PCResult + 4 from the PC adder.
- Stall  input  1  hazard stall; holds the PC.
- BranchTaken  input  1  conditional branch resolved taken.
- BranchTarget  input  32  branch target address.
- Jump  input  1  j/jal.
- JumpIndex  input  26  instruction index field.
- JumpReg  input  1  jr/jalr.
- JumpRegTarget  input  32  register-sourced target.
- PCResult  output  32  current PC (registered).
- PCValid  output  1  PCResult is a fetchable address.
- RedirectPending  output  1  a redirect is held awaiting stall release.
- Misaligned  output  1  sticky flag: a redirect target had bits[1:0] != 0.

Behaviour:
- Reset low, asynchronous:
  - PCResult=RESET_PC, PCValid=0, RedirectPending=0, Misaligned=0.
  - Pending register cleared; state=BOOT.
  - Reset asserted mid-stall or with a redirect pending discards all held state.
- FSM states:
  - BOOT: one cycle after reset release. PC held at RESET_PC, PCValid=0. Next edge -> RUN, PCValid=1. Stall and redirects are ignored in BOOT.
  - RUN, Stall=0: PC <= selected next PC (1-cycle latency).
  - RUN, Stall=1, no redirect: PC held.
  - RUN, Stall=1, redirect asserted: capture target into pending, RedirectPending=1 -> HOLD. PC held.
  - HOLD, Stall=1: PC held. A new redirect overwrites pending (newest wins).
  - HOLD, Stall=0: PC <= pending target, or <= a simultaneous new redirect target, which wins. RedirectPending=0 -> RUN.
- Next-PC priority: JumpReg > BranchTaken > Jump > sequential (PCAddResult).
- Jump target = {PCAddResult[31:28], JumpIndex, 2'b00}, computed from the PCAddResult present in the cycle Jump is sampled.
- Alignment:
  - Any JumpReg/Branch target with bits[1:0] != 0 is loaded with bits[1:0] forced to 0.
  - Misaligned then sets and stays set until reset.
- Wrap-around: PCAddResult of 32'hFFFFFFFC+4 = 0 is accepted as-is; no special handling.
- PCValid stays 1 after BOOT, including during stalls.

Optional Feature:
- PC_EXC_VECTOR_EN defined:
  - Adds input Exception (1 bit), highest priority above JumpReg.
  - On an Exception edge: PC <= EXC_VECTOR regardless of Stall. Pending is cleared, RedirectPending=0, state -> RUN.
  - In BOOT, Exception is ignored.
- PC_EXC_VECTOR_EN undefined: no Exception port, no exception logic; EXC_VECTOR is unused.

Test Plan:
- Reset release, no redirects, PCAddResult modelled as PC+4 -> BOOT cycle PC=0, PCValid=0; then PC 0,4,8,12 on successive edges, PCValid=1.
- PC=0x100, BranchTaken=1, BranchTarget=0x200, Jump=1, JumpIndex=0x40 same cycle -> next PC=0x200. Next cycle JumpReg=1, JumpRegTarget=0x300, BranchTaken=1 -> PC=0x300.
- PC=0x100, Stall=1 for 3 cycles, BranchTaken=1 (target 0x400) in stall cycle 1 only -> PC stays 0x100 and RedirectPending=1 for 3 cycles; first edge after Stall=0 gives PC=0x400, RedirectPending=0.
- While HOLD with pending 0x400, Jump=1, JumpIndex=0x10 in the Stall-release cycle, PCAddResult=0x104 -> PC=0x00000040.
- JumpReg=1, JumpRegTarget=0x1003 -> PC=0x1000, Misaligned=1, still 1 after 10 further cycles. Reset low asynchronously mid-cycle -> PC=0, Misaligned=0 immediately.
- PC_EXC_VECTOR_EN: Stall=1, pending=0x400, Exception=1 -> next PC=0x80000180, RedirectPending=0. After Stall release, PC continues 0x80000184.
